// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble scheduler beside ID: load-use and branch-operand hazard detection
// against an EXE/MEM destination scoreboard, mul/div busy sequencing and memory freeze.
module pipeline_hazard_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ID_valid,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_uses_rs,
  input  logic       ID_uses_rt,
  input  logic [4:0] ID_dest,
  input  logic       ID_writes,
  input  logic       ID_load,
  input  logic       ID_branch,
  input  logic       ID_muldiv,
  input  logic       ID_div,
  input  logic       ID_hilo_read,
  input  logic       MEM_freeze_req,
  output logic       STALL_FRONT,
  output logic       BUBBLE_EXE,
  output logic       FREEZE_ALL,
  output logic       MD_START,
  output logic       MD_BUSY,
  output logic [1:0] STALL_CAUSE
);

  typedef struct packed {
    logic       wr;
    logic [4:0] dest;
    logic       load;
  } sb_ent_t;

  typedef enum logic {IDLE, BUSY} md_state_t;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LATENCY - 1);

  // A producer in WB is never a hazard (forwarded / write-first regfile), so the
  // WB slot of the shifting scoreboard would be dead state and is not kept.
  sb_ent_t   sb_exe, sb_mem;
  md_state_t state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic hit_exe, hit_mem, haz_lu, haz_br, haz_md, accept;

  function automatic logic src_match(input sb_ent_t e, input logic [4:0] r, input logic use_r);
    return use_r && e.wr && (e.dest == r) && (r != 5'd0);
  endfunction

  always_comb begin
    hit_exe = src_match(sb_exe, ID_rs, ID_uses_rs) || src_match(sb_exe, ID_rt, ID_uses_rt);
    hit_mem = src_match(sb_mem, ID_rs, ID_uses_rs) || src_match(sb_mem, ID_rt, ID_uses_rt);
    haz_lu  = ID_valid && hit_exe && sb_exe.load;
    haz_br  = ID_valid && ID_branch && (hit_exe || (hit_mem && sb_mem.load));
    haz_md  = ID_valid && (state == BUSY) && (ID_muldiv || ID_hilo_read);
  end

  always_comb begin
    STALL_FRONT = 1'b0;
    BUBBLE_EXE  = 1'b0;
    FREEZE_ALL  = 1'b0;
    STALL_CAUSE = 2'd0;
    if (!RESET) begin
      if (MEM_freeze_req) begin
        FREEZE_ALL  = 1'b1;
        STALL_FRONT = 1'b1;
      end else if (haz_lu || haz_br || haz_md) begin
        STALL_FRONT = 1'b1;
        BUBBLE_EXE  = 1'b1;
        STALL_CAUSE = haz_lu ? 2'd1 : (haz_br ? 2'd2 : 2'd3);
      end
    end
  end

  assign accept = ID_valid && !STALL_FRONT && !RESET;

  // Scoreboard holds across freezes so the hazard re-evaluates against the same view.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sb_exe <= '0;
      sb_mem <= '0;
    end else if (!MEM_freeze_req) begin
      sb_mem <= sb_exe;
      sb_exe <= accept ? {ID_writes && (ID_dest != 5'd0), ID_dest, ID_load} : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter runs through freezes; the unit is independent of pipeline holds.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (accept && ID_muldiv) begin
        state_nxt = BUSY;
        cnt_nxt   = ID_div ? DIV_CNT : MUL_CNT;
      end
      BUSY: begin
        cnt_nxt = cnt - 6'd1;
        if (cnt == 6'd0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MD_BUSY  = (state == BUSY) && !RESET;
    MD_START = (state == IDLE) && accept && ID_muldiv;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench: driver queues the hand-computed per-cycle expectation,
// an independent monitor pops and compares on the falling edge.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] dest;
    logic       wr, ld, br, md, dv, hl;
  } instr_t;

  // {STALL_FRONT, BUBBLE_EXE, FREEZE_ALL, MD_START, MD_BUSY, STALL_CAUSE}
  typedef logic [6:0] exp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic frz = 1'b0;
  instr_t cur = '0;
  logic STALL_FRONT, BUBBLE_EXE, FREEZE_ALL, MD_START, MD_BUSY;
  logic [1:0] STALL_CAUSE;

  exp_t  exp_q[$];
  string name_q[$];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.MUL_LATENCY(4), .DIV_LATENCY(32)) dut (
    .CLK(CLK), .RESET(RESET), .ID_valid(cur.v), .ID_rs(cur.rs), .ID_rt(cur.rt),
    .ID_uses_rs(cur.urs), .ID_uses_rt(cur.urt), .ID_dest(cur.dest), .ID_writes(cur.wr),
    .ID_load(cur.ld), .ID_branch(cur.br), .ID_muldiv(cur.md), .ID_div(cur.dv),
    .ID_hilo_read(cur.hl), .MEM_freeze_req(frz), .STALL_FRONT(STALL_FRONT),
    .BUBBLE_EXE(BUBBLE_EXE), .FREEZE_ALL(FREEZE_ALL), .MD_START(MD_START),
    .MD_BUSY(MD_BUSY), .STALL_CAUSE(STALL_CAUSE)
  );

  function automatic instr_t nop();
    return '0;
  endfunction
  function automatic instr_t lw(input logic [4:0] d, input logic [4:0] base);
    instr_t i = '0;
    i.v = 1; i.rs = base; i.urs = 1; i.dest = d; i.wr = 1; i.ld = 1;
    return i;
  endfunction
  function automatic instr_t alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    instr_t i = '0;
    i.v = 1; i.rs = s; i.rt = t; i.urs = 1; i.urt = 1; i.dest = d; i.wr = 1;
    return i;
  endfunction
  function automatic instr_t beq(input logic [4:0] s, input logic [4:0] t);
    instr_t i = '0;
    i.v = 1; i.rs = s; i.rt = t; i.urs = 1; i.urt = 1; i.br = 1;
    return i;
  endfunction
  function automatic instr_t muldiv(input logic [4:0] s, input logic [4:0] t, input logic is_div);
    instr_t i = '0;
    i.v = 1; i.rs = s; i.rt = t; i.urs = 1; i.urt = 1; i.md = 1; i.dv = is_div;
    return i;
  endfunction
  function automatic instr_t mfhilo(input logic [4:0] d);
    instr_t i = '0;
    i.v = 1; i.dest = d; i.wr = 1; i.hl = 1;
    return i;
  endfunction
  function automatic exp_t E(input logic st, input logic bu, input logic fr,
                             input logic ms, input logic mb, input logic [1:0] ca);
    return {st, bu, fr, ms, mb, ca};
  endfunction

  localparam exp_t IDLE0 = 7'b0;

  task automatic cyc(input string nm, input instr_t i, input logic f, input logic r, input exp_t e);
    @(posedge CLK);
    #1;
    cur = i; frz = f; RESET = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every cycle with a queued expectation is compared at the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        exp_t e;
        exp_t a;
        string nm;
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        a = {STALL_FRONT, BUBBLE_EXE, FREEZE_ALL, MD_START, MD_BUSY, STALL_CAUSE};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got stall/bub/frz/start/busy/cause=%b required %b", nm, a, e);
        end
      end
    end
  end

  initial begin
    // Reset, with a would-be hazard sitting in ID
    cyc("reset0", alu(5'd6, 5'd5, 5'd1), 0, 1, IDLE0);
    cyc("reset1", muldiv(5'd1, 5'd2, 0), 0, 1, IDLE0);
    cyc("post_reset", nop(), 0, 0, IDLE0);

    // Load-use: one bubble
    cyc("lu_lw", lw(5'd5, 5'd1), 0, 0, IDLE0);
    cyc("lu_stall", alu(5'd6, 5'd5, 5'd1), 0, 0, E(1, 1, 0, 0, 0, 2'd1));
    cyc("lu_accept", alu(5'd6, 5'd5, 5'd1), 0, 0, IDLE0);
    cyc("lu_drain", nop(), 0, 0, IDLE0);

    // Branch behind ALU producer: one cycle
    cyc("br_alu_prod", alu(5'd3, 5'd1, 5'd2), 0, 0, IDLE0);
    cyc("br_alu_stall", beq(5'd4, 5'd3), 0, 0, E(1, 1, 0, 0, 0, 2'd2));
    cyc("br_alu_accept", beq(5'd4, 5'd3), 0, 0, IDLE0);
    cyc("br_drain", nop(), 0, 0, IDLE0);

    // Branch behind load: load-use wins the first cycle, branch cause the second
    cyc("br_lw_prod", lw(5'd3, 5'd2), 0, 0, IDLE0);
    cyc("br_lw_stall1", beq(5'd3, 5'd4), 0, 0, E(1, 1, 0, 0, 0, 2'd1));
    cyc("br_lw_stall2", beq(5'd3, 5'd4), 0, 0, E(1, 1, 0, 0, 0, 2'd2));
    cyc("br_lw_accept", beq(5'd3, 5'd4), 0, 0, IDLE0);

    // Register 0 never stalls
    cyc("r0_lw", lw(5'd0, 5'd1), 0, 0, IDLE0);
    cyc("r0_use", alu(5'd6, 5'd0, 5'd0), 0, 0, IDLE0);
    cyc("r0_beq", beq(5'd0, 5'd0), 0, 0, IDLE0);
    cyc("r0_drain", nop(), 0, 0, IDLE0);
    cyc("r0_drain2", nop(), 0, 0, IDLE0);

    // Freeze over a load-use: freeze wins 3 cycles, then one bubble
    cyc("fz_lw", lw(5'd7, 5'd1), 0, 0, IDLE0);
    for (int k = 0; k < 3; k++)
      cyc($sformatf("fz_hold%0d", k), alu(5'd8, 5'd7, 5'd1), 1, 0, E(1, 0, 1, 0, 0, 2'd0));
    cyc("fz_lu_stall", alu(5'd8, 5'd7, 5'd1), 0, 0, E(1, 1, 0, 0, 0, 2'd1));
    cyc("fz_accept", alu(5'd8, 5'd7, 5'd1), 0, 0, IDLE0);
    cyc("fz_drain", nop(), 0, 0, IDLE0);

    // Mult stalled by load-use gets no start strobe until accepted
    cyc("ms_lw", lw(5'd2, 5'd1), 0, 0, IDLE0);
    cyc("ms_stalled", muldiv(5'd2, 5'd3, 0), 0, 0, E(1, 1, 0, 0, 0, 2'd1));
    cyc("ms_start", muldiv(5'd2, 5'd3, 0), 0, 0, E(0, 0, 0, 1, 0, 2'd0));
    // busy t+1..t+4: independent ALU passes, mfhi waits, freeze does not stop the count
    cyc("mul_alu", alu(5'd9, 5'd1, 5'd2), 0, 0, E(0, 0, 0, 0, 1, 2'd0));
    cyc("mul_frz", mfhilo(5'd10), 1, 0, E(1, 0, 1, 0, 1, 2'd0));
    cyc("mul_hi3", mfhilo(5'd10), 0, 0, E(1, 1, 0, 0, 1, 2'd3));
    cyc("mul_hi4", mfhilo(5'd10), 0, 0, E(1, 1, 0, 0, 1, 2'd3));
    cyc("mul_hi_accept", mfhilo(5'd10), 0, 0, IDLE0);

    // Div: 32 busy cycles, mflo waits through all of them
    cyc("div_start", muldiv(5'd4, 5'd5, 1), 0, 0, E(0, 0, 0, 1, 0, 2'd0));
    for (int k = 1; k <= 32; k++)
      cyc($sformatf("div_lo%0d", k), mfhilo(5'd11), 0, 0, E(1, 1, 0, 0, 1, 2'd3));
    cyc("div_lo_accept", mfhilo(5'd11), 0, 0, IDLE0);
    cyc("div_drain", nop(), 0, 0, IDLE0);

    // Reset while BUSY with cnt=10: aborts FSM and clears scoreboard
    cyc("rb_start", muldiv(5'd4, 5'd5, 1), 0, 0, E(0, 0, 0, 1, 0, 2'd0));
    for (int k = 1; k <= 20; k++)
      cyc($sformatf("rb_busy%0d", k), nop(), 0, 0, E(0, 0, 0, 0, 1, 2'd0));
    cyc("rb_lw", lw(5'd5, 5'd1), 0, 0, E(0, 0, 0, 0, 1, 2'd0));
    cyc("rb_reset", alu(5'd6, 5'd5, 5'd1), 0, 1, IDLE0);
    cyc("rb_sb_clear", alu(5'd6, 5'd5, 5'd1), 0, 0, IDLE0);
    cyc("rb_mflo", mfhilo(5'd12), 0, 0, IDLE0);
    cyc("rb_end", nop(), 0, 0, IDLE0);

    begin
      int guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
        @(negedge CLK);
        guard++;
      end
      #1;
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
